decode_reg_read: RTL and testbench



---
 rtl/decode_reg_read_pkg.sv | 15 +
 rtl/decode_reg_read_reg_file.sv | 38 +++
 rtl/decode_reg_read.sv | 91 +++++++++
 tb/tb_decode_reg_read.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/decode_reg_read_pkg.sv
// Shared widths and the write-back write-port bundle for the decode/write-back pair.
package decode_reg_read_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam logic [ADDR_W-1:0] PRIVATE_ADDR = 4'hF;

  typedef struct packed {
    logic              regWrite;
    logic              dstOrPrivate;
    logic [ADDR_W-1:0] regDstAddress;
    logic [DATA_W-1:0] writeData;
  } wb_port_t;

endpackage

// File: rtl/decode_reg_read_reg_file.sv
// Register file with one write port and two combinational read ports that bypass
// a same-cycle write.
module decode_reg_read_reg_file
  import decode_reg_read_pkg::*;
#(
  parameter int unsigned         DW        = DATA_W,
  parameter int unsigned         AW        = ADDR_W,
  parameter logic [AW-1:0]       PRIV_ADDR = PRIVATE_ADDR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic          i_private,
  input  logic [AW-1:0] i_dst_addr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr1,
  input  logic [AW-1:0] i_raddr2,
  output logic [DW-1:0] o_rdata1,
  output logic [DW-1:0] o_rdata2
);

  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] w_waddr;

  assign w_waddr = i_private ? PRIV_ADDR : i_dst_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**AW; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[w_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_we && (w_waddr == i_raddr1)) ? i_wdata : r_mem[i_raddr1];
  assign o_rdata2 = (i_we && (w_waddr == i_raddr2)) ? i_wdata : r_mem[i_raddr2];

endmodule

// File: rtl/decode_reg_read.sv
// Decode-stage register read: register file plus the decode/execute pipeline register
// with flush > stall > normal priority.
module decode_reg_read
  import decode_reg_read_pkg::*;
#(
  parameter int unsigned           DATA_W       = decode_reg_read_pkg::DATA_W,
  parameter int unsigned           ADDR_W       = decode_reg_read_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]     PRIVATE_ADDR = decode_reg_read_pkg::PRIVATE_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regWrite,
  input  logic              dstOrPrivate,
  input  logic [ADDR_W-1:0] regDstAddress,
  input  logic [DATA_W-1:0] writeData,
  input  logic              inValid,
  input  logic [ADDR_W-1:0] src1Address,
  input  logic [ADDR_W-1:0] src2Address,
  input  logic              stall,
  input  logic              flush,
  output logic              outValid,
  output logic [ADDR_W-1:0] outSrc1Address,
  output logic [ADDR_W-1:0] outSrc2Address,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_src1;
  logic [ADDR_W-1:0] r_src2;
  logic [DATA_W-1:0] r_data1;
  logic [DATA_W-1:0] r_data2;

  logic [ADDR_W-1:0] w_raddr1;
  logic [ADDR_W-1:0] w_raddr2;
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;

  // While stalled, re-read the held indices so writes landing during the stall are seen.
  assign w_raddr1 = stall ? r_src1 : src1Address;
  assign w_raddr2 = stall ? r_src2 : src2Address;

  decode_reg_read_reg_file #(
    .DW        (DATA_W),
    .AW        (ADDR_W),
    .PRIV_ADDR (PRIVATE_ADDR)
  ) u_reg_file (
    .clk        (clk),
    .rst        (rst),
    .i_we       (regWrite),
    .i_private  (dstOrPrivate),
    .i_dst_addr (regDstAddress),
    .i_wdata    (writeData),
    .i_raddr1   (w_raddr1),
    .i_raddr2   (w_raddr2),
    .o_rdata1   (w_rdata1),
    .o_rdata2   (w_rdata2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_src1  <= '0;
      r_src2  <= '0;
      r_data1 <= '0;
      r_data2 <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_src1  <= '0;
      r_src2  <= '0;
      r_data1 <= '0;
      r_data2 <= '0;
    end else if (stall) begin
      r_data1 <= w_rdata1;
      r_data2 <= w_rdata2;
    end else begin
      r_valid <= inValid;
      r_src1  <= src1Address;
      r_src2  <= src2Address;
      r_data1 <= w_rdata1;
      r_data2 <= w_rdata2;
    end
  end

  assign outValid       = r_valid;
  assign outSrc1Address = r_src1;
  assign outSrc2Address = r_src2;
  assign readData1      = r_data1;
  assign readData2      = r_data2;

endmodule

// File: tb/tb_decode_reg_read.sv
// Directed self-checking bench for decode_reg_read.
module tb_decode_reg_read;

  logic        clk = 1'b0;
  logic        rst;
  logic        regWrite;
  logic        dstOrPrivate;
  logic [3:0]  regDstAddress;
  logic [15:0] writeData;
  logic        inValid;
  logic [3:0]  src1Address;
  logic [3:0]  src2Address;
  logic        stall;
  logic        flush;
  logic        outValid;
  logic [3:0]  outSrc1Address;
  logic [3:0]  outSrc2Address;
  logic [15:0] readData1;
  logic [15:0] readData2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_reg_read dut (
    .clk            (clk),
    .rst            (rst),
    .regWrite       (regWrite),
    .dstOrPrivate   (dstOrPrivate),
    .regDstAddress  (regDstAddress),
    .writeData      (writeData),
    .inValid        (inValid),
    .src1Address    (src1Address),
    .src2Address    (src2Address),
    .stall          (stall),
    .flush          (flush),
    .outValid       (outValid),
    .outSrc1Address (outSrc1Address),
    .outSrc2Address (outSrc2Address),
    .readData1      (readData1),
    .readData2      (readData2)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic en, input logic priv, input logic [3:0] a,
                       input logic [15:0] d);
    regWrite = en; dstOrPrivate = priv; regDstAddress = a; writeData = d;
  endtask

  task automatic read(input logic v, input logic [3:0] a1, input logic [3:0] a2);
    inValid = v; src1Address = a1; src2Address = a2;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    write(1'b0, 1'b0, 4'd0, 16'h0000);
    read(1'b0, 4'd0, 4'd0);
    #3;
    check("reset_valid", outValid, 16'h0);
    check("reset_rd1", readData1, 16'h0);
    check("reset_src2", outSrc2Address, 16'h0);
    @(negedge clk); rst = 1'b0;
    tick();

    // Write R3 then read it back
    write(1'b1, 1'b0, 4'd3, 16'hBEEF);
    tick();
    write(1'b0, 1'b0, 4'd0, 16'h0000);
    read(1'b1, 4'd3, 4'd0);
    tick();
    check("wr_rd_data1", readData1, 16'hBEEF);
    check("wr_rd_valid", outValid, 16'h1);
    check("wr_rd_src1", outSrc1Address, 16'h3);

    // Same-cycle bypass on both ports
    write(1'b1, 1'b0, 4'd5, 16'h1234);
    read(1'b1, 4'd5, 4'd5);
    tick();
    check("bypass_rd1", readData1, 16'h1234);
    check("bypass_rd2", readData2, 16'h1234);

    // Private write lands in R15, not R2
    write(1'b1, 1'b1, 4'd2, 16'hA5A5);
    read(1'b1, 4'd2, 4'd15);
    tick();
    check("priv_bypass_r2", readData1, 16'h0000);
    check("priv_bypass_r15", readData2, 16'hA5A5);
    write(1'b0, 1'b0, 4'd0, 16'h0000);
    read(1'b1, 4'd15, 4'd2);
    tick();
    check("priv_file_r15", readData1, 16'hA5A5);
    check("priv_file_r2", readData2, 16'h0000);

    // Stall refresh from held indices
    read(1'b1, 4'd4, 4'd3);
    tick();
    check("pre_stall_rd1", readData1, 16'h0000);
    check("pre_stall_rd2", readData2, 16'hBEEF);
    stall = 1'b1;
    read(1'b0, 4'd9, 4'd9);
    tick();
    check("stall1_valid", outValid, 16'h1);
    check("stall1_src1", outSrc1Address, 16'h4);
    check("stall1_rd1", readData1, 16'h0000);
    write(1'b1, 1'b0, 4'd4, 16'h0042);
    tick();
    check("stall2_rd1", readData1, 16'h0042);
    check("stall2_src1", outSrc1Address, 16'h4);
    write(1'b0, 1'b0, 4'd0, 16'h0000);
    tick();
    check("stall3_rd1", readData1, 16'h0042);
    check("stall3_rd2", readData2, 16'hBEEF);
    check("stall3_valid", outValid, 16'h1);

    // Flush beats stall; concurrent write still lands
    flush = 1'b1;
    write(1'b1, 1'b0, 4'd7, 16'h7777);
    tick();
    check("flush_valid", outValid, 16'h0);
    check("flush_rd1", readData1, 16'h0000);
    check("flush_rd2", readData2, 16'h0000);
    check("flush_src1", outSrc1Address, 16'h0);
    flush = 1'b0; stall = 1'b0;
    write(1'b0, 1'b0, 4'd0, 16'h0000);
    read(1'b0, 4'd7, 4'd5);
    tick();
    check("post_flush_r7", readData1, 16'h7777);
    check("invalid_data_r5", readData2, 16'h1234);
    check("invalid_valid", outValid, 16'h0);

    // Async reset mid-cycle discards an in-flight write
    write(1'b1, 1'b0, 4'd6, 16'hFFFF);
    read(1'b1, 4'd6, 4'd5);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rd1", readData1, 16'h0000);
    check("async_rst_rd2", readData2, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    write(1'b0, 1'b0, 4'd0, 16'h0000);
    read(1'b1, 4'd6, 4'd5);
    tick();
    check("post_rst_r6", readData1, 16'h0000);
    check("post_rst_r5", readData2, 16'h0000);
    check("post_rst_valid", outValid, 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
